// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the five-stage pipeline.
// It drives the stage stalls and flushes and the operand-forwarding selects.
// It sequences data-memory waits under a watchdog and holds the core halted
// after an ebreak or a memory timeout.
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255,
  parameter int WAIT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_reg_wen,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
  input  logic                  ex_is_load,
  input  logic                  mem_reg_wen,
  input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
  input  logic                  mem_is_load,
  input  logic                  wb_reg_wen,
  input  logic [REG_ADDR_W-1:0] wb_reg_waddr,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  wb_ebreak,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic [1:0]            fwd_rs1,
  output logic [1:0]            fwd_rs2,
  output logic                  halted,
  output logic                  mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic [WAIT_W-1:0] w_wait_cnt_inc;
  logic              r_mem_timeout;
  logic              w_mem_timeout_next;
  logic              w_load_use;
  logic              w_mem_stall_start;

  // Forwarding select for one source: the MEM stage beats WB, and x0 or an
  // unused source always reads the register file.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used,
    input logic                  m_wen,
    input logic [REG_ADDR_W-1:0] m_waddr,
    input logic                  m_load,
    input logic                  w_wen,
    input logic [REG_ADDR_W-1:0] w_waddr
  );
    logic [1:0] sel;
    if (!used || (rs == {REG_ADDR_W{1'b0}})) begin
      sel = 2'd0;
    end else if (m_wen && (m_waddr == rs)) begin
      sel = m_load ? 2'd2 : 2'd1;
    end else if (w_wen && (w_waddr == rs)) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign fwd_rs1 = fwd_sel(id_rs1, id_rs1_used, mem_reg_wen, mem_reg_waddr,
                           mem_is_load, wb_reg_wen, wb_reg_waddr);
  assign fwd_rs2 = fwd_sel(id_rs2, id_rs2_used, mem_reg_wen, mem_reg_waddr,
                           mem_is_load, wb_reg_wen, wb_reg_waddr);

  assign w_load_use = ex_is_load && ex_reg_wen &&
                      (ex_reg_waddr != {REG_ADDR_W{1'b0}}) &&
                      ((id_rs1_used && (id_rs1 == ex_reg_waddr)) ||
                       (id_rs2_used && (id_rs2 == ex_reg_waddr)));
  assign w_mem_stall_start = mem_req && !mem_ack;
  assign w_wait_cnt_inc    = r_wait_cnt + 1'b1;
  assign mem_timeout       = r_mem_timeout;

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= {WAIT_W{1'b0}};
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_wait_cnt    <= w_wait_cnt_next;
      r_mem_timeout <= w_mem_timeout_next;
    end
  end

  // Next state and stage controls; redirect outranks load-use once no memory wait is pending.
  always_comb begin
    w_next_state       = r_state;
    w_wait_cnt_next    = r_wait_cnt;
    w_mem_timeout_next = r_mem_timeout;
    pc_stall           = 1'b0;
    if_id_stall        = 1'b0;
    id_ex_stall        = 1'b0;
    ex_mem_stall       = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    mem_wb_flush       = 1'b0;
    halted             = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_wait_cnt_next = {WAIT_W{1'b0}};
        if (w_mem_stall_start) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_stall = 1'b0;
        end
        if (wb_ebreak) begin
          w_next_state = ST_HALT;
        end else if (w_mem_stall_start) begin
          w_next_state = ST_MEM_WAIT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          // Release cycle: a redirect held in the frozen EX stage acts now.
          w_next_state    = ST_RUN;
          w_wait_cnt_next = {WAIT_W{1'b0}};
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_stall = 1'b0;
          end
        end else begin
          pc_stall        = 1'b1;
          if_id_stall     = 1'b1;
          id_ex_stall     = 1'b1;
          ex_mem_stall    = 1'b1;
          mem_wb_flush    = 1'b1;
          w_wait_cnt_next = w_wait_cnt_inc;
          if (w_wait_cnt_inc == WAIT_W'(MAX_WAIT)) begin
            w_next_state       = ST_HALT;
            w_mem_timeout_next = 1'b1;
          end else begin
            w_next_state = ST_MEM_WAIT;
          end
        end
      end
      ST_HALT: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
        halted       = 1'b1;
      end
      default: begin
        w_next_state    = ST_RUN;
        w_wait_cnt_next = {WAIT_W{1'b0}};
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  // Stall and flush cycle counters; they wrap naturally and freeze while halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else if (r_state != ST_HALT) begin
      if (pc_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (if_id_flush) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MAX_WAIT reduced to 4).
// Expected control vectors are queued as stimulus is applied and popped and
// compared when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_reg_waddr, mem_reg_waddr, wb_reg_waddr;
  logic          id_rs1_used, id_rs2_used, ex_reg_wen, ex_is_load;
  logic          mem_reg_wen, mem_is_load, wb_reg_wen;
  logic          ex_redirect, mem_req, mem_ack, wb_ebreak;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic          if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]    fwd_rs1, fwd_rs2;
  logic          halted, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;
  logic [31:0]   m_stall = 32'd0;
  logic [31:0]   m_flush = 32'd0;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [12:0]   exp_q[$];
  string         tag_q[$];
  logic [12:0]   obs;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MAX_WAIT(MW), .WAIT_W(WW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr), .ex_is_load(ex_is_load),
    .mem_reg_wen(mem_reg_wen), .mem_reg_waddr(mem_reg_waddr), .mem_is_load(mem_is_load),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .wb_ebreak(wb_ebreak),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // free-running clock, 10 ns period
  always #5 clk = ~clk;

  assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_flush,
                fwd_rs1, fwd_rs2, halted, mem_timeout};

  task automatic check_eq(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs_v, exp_v);
    end
  endtask

  // Pack an expected control vector: stalls {pc,if_id,id_ex,ex_mem}, flushes {if_id,id_ex,mem_wb}.
  function automatic logic [12:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] f1, input logic [1:0] f2,
                                     input logic h, input logic t);
    return {st, fl, f1, f2, h, t};
  endfunction

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_reg_wen = 1'b0; ex_reg_waddr = '0; ex_is_load = 1'b0;
    mem_reg_wen = 1'b0; mem_reg_waddr = '0; mem_is_load = 1'b0;
    wb_reg_wen = 1'b0; wb_reg_waddr = '0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; wb_ebreak = 1'b0;
  endtask

  task automatic ex_load(input logic [AW-1:0] rd);
    ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = rd;
  endtask

  // Queue the expected vector for the cycle just driven, then sample and compare.
  task automatic cyc(input string tag, input logic [12:0] e);
    logic [12:0] x;
    string       tg;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x  = exp_q.pop_front();
    tg = tag_q.pop_front();
    check_eq(tg, {19'd0, obs}, {19'd0, x});
`ifdef PIPE_CTRL_PERF_EN
    if (rst) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end
    check_eq({tg, "_perf_stall"}, perf_stall_cnt, m_stall);
    check_eq({tg, "_perf_flush"}, perf_flush_cnt, m_flush);
    if (x[12] && !x[1]) m_stall = m_stall + 32'd1;
    if (x[8]) m_flush = m_flush + 32'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] ALL_ST = 4'hF;

  initial begin
    rst = 1'b1;
    clear_in();
    #1;
    cyc("reset", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // load-use on rs2, then forwarding from the load in MEM
    ex_load(5'd5); id_rs2 = 5'd5; id_rs2_used = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    cyc("load_use_rs2", ev(4'b1100, 3'b010, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    mem_reg_wen = 1'b1; mem_reg_waddr = 5'd5; mem_is_load = 1'b1;
    id_rs2 = 5'd5; id_rs2_used = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    cyc("load_fwd_sel2", ev(4'h0, 3'b000, 2'd0, 2'd2, 1'b0, 1'b0));
    clear_in(); ex_load(5'd5); id_rs1 = 5'd5; id_rs2 = 5'd5;
    cyc("load_use_unused", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in(); ex_load(5'd0); id_rs1 = 5'd0; id_rs1_used = 1'b1;
    cyc("load_use_x0", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in(); ex_load(5'd9); id_rs1 = 5'd9; id_rs1_used = 1'b1;
    cyc("load_use_rs1", ev(4'b1100, 3'b010, 2'd0, 2'd0, 1'b0, 1'b0));

    // forwarding priority
    clear_in();
    mem_reg_wen = 1'b1; mem_reg_waddr = 5'd7; wb_reg_wen = 1'b1; wb_reg_waddr = 5'd7;
    id_rs1 = 5'd7; id_rs1_used = 1'b1; id_rs2 = 5'd7;
    cyc("fwd_mem_over_wb", ev(4'h0, 3'b000, 2'd1, 2'd0, 1'b0, 1'b0));
    mem_reg_waddr = 5'd0; wb_reg_waddr = 5'd0; id_rs1 = 5'd0;
    cyc("fwd_x0", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_reg_waddr = 5'd8; wb_reg_waddr = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd8; id_rs2_used = 1'b1;
    cyc("fwd_wb_and_mem", ev(4'h0, 3'b000, 2'd3, 2'd1, 1'b0, 1'b0));
    mem_reg_waddr = 5'd7; mem_is_load = 1'b1; id_rs2_used = 1'b0;
    cyc("fwd_mem_load", ev(4'h0, 3'b000, 2'd2, 2'd0, 1'b0, 1'b0));

    // redirect, alone and against load-use
    clear_in(); ex_redirect = 1'b1;
    cyc("redirect", ev(4'h0, 3'b110, 2'd0, 2'd0, 1'b0, 1'b0));
    ex_load(5'd4); id_rs1 = 5'd4; id_rs1_used = 1'b1;
    cyc("redirect_over_load_use", ev(4'h0, 3'b110, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    cyc("redirect_done", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));

    // memory access: same-cycle ack, then a three-cycle wait
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc("mem_ack_same", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mem_wait", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_ack = 1'b1;
    cyc("mem_release", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    cyc("mem_idle", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));

    // redirect held during the wait, acting on the ack cycle only
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cyc("redir_wait", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_ack = 1'b1;
    cyc("redir_on_ack", ev(4'h0, 3'b110, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    cyc("redir_once", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));

    // ack on the last cycle before the watchdog fires
    mem_req = 1'b1;
    for (int i = 0; i < MW; i++) cyc("late_wait", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_ack = 1'b1;
    cyc("late_ack", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    cyc("late_idle", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));

    // watchdog timeout: MAX_WAIT+1 stall cycles, then sticky halt until reset
    mem_req = 1'b1;
    for (int i = 0; i < MW + 1; i++) cyc("to_wait", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0));
    cyc("to_halt", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1));
    clear_in();
    cyc("to_hold", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1));
    rst = 1'b1;
    cyc("rst_from_halt", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // reset in the middle of a wait
    mem_req = 1'b1;
    for (int i = 0; i < 2; i++) cyc("rw_wait", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in(); rst = 1'b1;
    cyc("rst_mid_wait", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;
    cyc("after_rst", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));

    // ebreak halts on the next cycle; redirects are ignored while halted
    ex_redirect = 1'b1;
    cyc("pre_ebreak_flush", ev(4'h0, 3'b110, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in(); wb_ebreak = 1'b1;
    cyc("ebreak_cycle", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    clear_in();
    cyc("ebreak_halt", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0));
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc("halt_hold", ev(ALL_ST, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0));
    clear_in(); rst = 1'b1;
    cyc("rst_after_ebreak", ev(4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
